pc_bcd_converter: RTL
=====================

Name: pc_bcd_converter

Overview:
- Sequential binary-to-BCD converter that produces the two decimal digits driving the FPGA seven-segment digit decoder (tens digit to the first display, ones digit to the second).
- Takes a binary program-counter-derived value from the datapath and converts it with a double-dabble (shift-and-add-3) FSM, one iteration per clock.
- Values above 99 produce the blank code 4'hF on both digits, which the display decoder renders as all segments off.

Parameters:
WIDTH, 7, width of the binary input; legal range 4..9, so the maximum value 511 keeps the hundreds nibble at 5 or below.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion of bin; sampled only in IDLE
bin  input  WIDTH  unsigned binary value, captured on the accepted start edge
tens  output  4  BCD tens digit (0..9), or 4'hF on overflow
ones  output  4  BCD ones digit (0..9), or 4'hF on overflow
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when tens/ones/overflow update
overflow  output  1  high when the last converted value was greater than 99

Behaviour:
- Clock and reset: one clock, clk. The reset is synchronous and active-high, named reset. On reset, state is IDLE; tens=0, ones=0 (the display shows "00"); busy=0; done=0; overflow=0; the shift register and the iteration counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1 at an edge, capture bin into the binary part of the shift register and clear the BCD nibbles (hundreds, tens, ones).
  - Load the iteration counter with WIDTH.
  - Next state is SHIFT; busy=1 from this edge.
  - When start=0, stay in IDLE.
- SHIFT, each cycle:
  - For each of the three BCD nibbles, add 3 if the nibble is 5 or greater, using 4-bit arithmetic per nibble.
  - Then shift the entire {hundreds, tens, ones, binary} register left by 1.
  - Decrement the counter. When the counter reaches 0, go to DONE.
  - There are exactly WIDTH SHIFT cycles.
- DONE, entered after the final shift:
  - If hundreds != 0, set overflow=1 and tens=ones=4'hF.
  - Otherwise set overflow=0, tens = tens nibble, ones = ones nibble.
  - done=1 for this single cycle, busy=0, and return to IDLE on the next edge.
- Latency: for a start sampled at edge 0, done is high and the outputs are valid after edge WIDTH+1. For WIDTH=7 that is 8 cycles.
- Output hold: tens, ones and overflow change only on entry to DONE and otherwise hold their last result, so the display never shows intermediate values.
- start while busy (SHIFT or DONE): ignored, with no queuing. bin changes during a conversion have no effect.
- start high in the cycle after DONE (state back in IDLE): accepted normally, so back-to-back conversions have no dead cycle beyond DONE.
- start held high continuously: conversions repeat every WIDTH+2 cycles.
- Reset mid-conversion: aborts immediately. No done pulse, and the outputs return to their reset values.
- busy and done are never high in the same cycle. done=1 implies busy=0.
- Purely synchronous: no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with bin=0 -> done exactly 8 cycles after the start edge (WIDTH=7); tens=0, ones=0, overflow=0; busy high for the 7 SHIFT cycles in between.
- bin=42, then bin=99, then bin=7 -> tens/ones = 4/2, 9/9, 0/7 respectively; overflow=0 each time; outputs hold between done pulses.
- bin=100 and bin=127 -> tens=4'hF, ones=4'hF, overflow=1. A following bin=10 -> tens=1, ones=0, overflow=0.
- start=1 with bin=55, then pulse start with bin=88 during SHIFT -> only one done; result 5/5. The second request is ignored, and bin changes mid-conversion have no effect.
- start held high, bin alternating 12/34 at each accepted start -> done pulses every 9 cycles with 1/2 then 3/4; busy and done are never both high.
- start with bin=63; assert reset on the 4th SHIFT cycle -> no done pulse; tens=0, ones=0, busy=0, overflow=0 on the following cycle. A next start with bin=63 -> 6/3.

Source files
------------

// File: rtl/pc_bcd_converter_if.sv
// rtl/pc_bcd_converter_if.sv - request/result bundle for the binary-to-BCD display converter
//
// Purpose: groups the start/bin request and the tens/ones/busy/done/overflow result
// of pc_bcd_converter so the datapath side and the display side connect as one port.
// Signals:
//   start    request a conversion of bin (master -> slave)
//   bin      unsigned binary value, WIDTH bits (master -> slave)
//   tens     BCD tens digit, 4'hF when blanked (slave -> master)
//   ones     BCD ones digit, 4'hF when blanked (slave -> master)
//   busy     conversion in progress (slave -> master)
//   done     one-cycle pulse when tens/ones/overflow update (slave -> master)
//   overflow last converted value was above 99 (slave -> master)

interface pc_bcd_converter_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, bin,
    input  tens, ones, busy, done, overflow
  );

  modport slave (
    input  start, bin,
    output tens, ones, busy, done, overflow
  );
endinterface

// File: rtl/pc_bcd_converter.sv
// rtl/pc_bcd_converter.sv - sequential double-dabble converter feeding the two seven-segment digits
//
// Purpose: converts a WIDTH-bit program-counter value into tens/ones BCD digits, one
// shift-and-add-3 iteration per clock. Values above 99 blank both digits (4'hF).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    pc_bcd_converter_if.slave: start/bin in; tens/ones/busy/done/overflow out
// Timing: start accepted at edge 0 -> WIDTH SHIFT cycles -> DONE -> results and the
// done pulse are registered out at edge WIDTH+1. WIDTH must stay within 4..9.

module pc_bcd_converter #(
  parameter int WIDTH = 7
) (
  input  logic              clk,
  input  logic              reset,
  pc_bcd_converter_if.slave bus
);

  // {hundreds, tens, ones, binary}
  localparam int SRW = WIDTH + 12;
  localparam int HUN = WIDTH + 8;
  localparam int TEN = WIDTH + 4;
  localparam int ONE = WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [SRW-1:0] sr_adj;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     ones_q, ones_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Per-nibble correction applied before each left shift.
  always_comb begin
    sr_adj = {add3(sr_q[HUN +: 4]), add3(sr_q[TEN +: 4]), add3(sr_q[ONE +: 4]),
              sr_q[WIDTH-1:0]};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sr_d    = {12'd0, bus.bin};
          cnt_d   = 4'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Result registers load only here so the display never sees partial digits.
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (sr_q[HUN +: 4] != 4'd0) begin
          ovf_d  = 1'b1;
          tens_d = 4'hF;
          ones_d = 4'hF;
        end else begin
          ovf_d  = 1'b0;
          tens_d = sr_q[TEN +: 4];
          ones_d = sr_q[ONE +: 4];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // busy is a decode of the state register only, so it can never overlap the
  // registered done pulse (which is high while the state is already back in IDLE).
  assign bus.busy     = (state_q == S_SHIFT);
  assign bus.done     = done_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign bus.overflow = ovf_q;

endmodule
